// File: rtl/hit_sound_sequencer.sv
// Turns per-lane hit strobes from two players into one-hot buzzer sound codes,
// queued in a 4-deep FIFO and spaced by a programmable silent hold window.
module hit_sound_sequencer #(
    parameter int unsigned HOLD_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hit_p1,
    input  logic [3:0] hit_p2,
    input  logic       enable,
    output logic [7:0] sound,
    output logic       busy,
    output logic       fifo_full,
    output logic [7:0] drop_count
);

    localparam logic [26:0] HOLD_LOAD = 27'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [26:0] hold_cnt;

    logic [7:0]  req;
    logic [7:0]  req_d;
    logic [7:0]  ev;
    logic        ev_any;
    logic        ev_multi;
    logic [2:0]  ev_idx;

    logic [2:0]  mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [2:0]  head;

    logic        pop;
    logic        push;
    logic        lost;

    always_comb begin
        req      = {hit_p1, hit_p2};
        ev       = req & ~req_d;
        ev_any   = |ev;
        // Clearing the lowest set bit leaves something only if two or more were set.
        ev_multi = |(ev & (ev - 8'd1));
        ev_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (ev[i]) ev_idx = 3'(i);
        end
    end

    always_comb begin
        head = mem[rd_ptr];
        pop  = enable && (state == IDLE) && (count != 3'd0);
        push = enable && ev_any && ((count != 3'd4) || pop);
        lost = enable && (ev_multi || (ev_any && !push));
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ev_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // Track live levels during reset so lanes held through it stay silent.
            req_d      <= req;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            count      <= 3'd0;
            drop_count <= 8'd0;
            state      <= IDLE;
            hold_cnt   <= 27'd0;
            sound      <= 8'h00;
        end else begin
            req_d <= req;

            if (!enable) begin
                wr_ptr <= 2'd0;
                rd_ptr <= 2'd0;
                count  <= 3'd0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 2'd1;
                if (pop)  rd_ptr <= rd_ptr + 2'd1;
                count <= count + 3'(push) - 3'(pop);
            end

            if (lost && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;

            case (state)
                IDLE: begin
                    if (pop) begin
                        sound    <= 8'd1 << head;
                        hold_cnt <= HOLD_LOAD;
                        state    <= HOLD;
                    end else begin
                        sound <= 8'h00;
                    end
                end
                HOLD: begin
                    sound <= 8'h00;
                    if (hold_cnt == 27'd0) state <= IDLE;
                    else                   hold_cnt <= hold_cnt - 27'd1;
                end
                default: begin
                    sound <= 8'h00;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == HOLD);
    assign fifo_full = (count == 3'd4);

endmodule

// File: doc/hit_sound_sequencer.md
# hit_sound_sequencer

Producer side of the buzzer sound-code interface. Converts per-lane hit strobes from both players into one-hot 8-bit sound codes. Each code is pulsed for exactly one clock. Consecutive pulses are spaced by a programmable hold window so the buzzer driver plays each tone for its full duration. A 4-entry FIFO absorbs bursts, and overflow or collision losses are counted.

## Interface
- HOLD_CYCLES, 25000000: cycles of silence enforced after each emitted code; range 1..2^27-1.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- hit_p1  input  4  player-1 lane levels, bit3..bit0; map to sound bits 7..4.
- hit_p2  input  4  player-2 lane levels, bit3..bit0; map to sound bits 3..0.
- enable  input  1  high = sequencer active; low = mute and flush.
- sound  output  8  one-hot code, valid for one cycle; 8'h00 otherwise.
- busy  output  1  high while the hold window is running.
- fifo_full  output  1  high when the FIFO holds 4 entries.
- drop_count  output  8  saturating count of cycles in which an event was lost.

## Operation
- Edge detect:
  - Registered copy req_d of {hit_p1, hit_p2}.
  - Events are ev = {hit_p1, hit_p2} & ~req_d.
  - While rst is low, req_d loads the live inputs, so lanes held through reset do not fire.
- Selection: each cycle, at most one event is selected, namely the highest asserted bit of ev (bit7 highest). It is encoded as a 3-bit index.
- Drop counting: drop_count increments by 1 (saturating at 255) in any cycle where either:
  - ev has more than one bit set, or
  - the selected event cannot be written because the FIFO is full and not popping.
- FIFO:
  - 4 entries × 3 bits, with 2-bit read/write pointers that wrap and a 3-bit occupancy count.
  - Push and pop in the same cycle is legal, including when full; the push is accepted.
- FSM states:
  - IDLE: if enable and FIFO non-empty, pop the head, register sound = 1<<index, load hold_cnt = HOLD_CYCLES-1, and go to HOLD. Otherwise sound = 0.
  - HOLD: sound = 0. If hold_cnt == 0, go to IDLE; else decrement hold_cnt. No pop occurs in HOLD.
- enable low:
  - New events are ignored: not queued, not counted.
  - The FIFO is flushed to empty each cycle.
  - A running HOLD completes normally.
  - No pop from IDLE.
- Derived outputs: busy = (state == HOLD); fifo_full = (count == 4).

## Timing
- Reset (rst low at a rising edge):
  - sound = 8'h00, busy = 0, fifo_full = 0, drop_count = 0.
  - State IDLE, FIFO empty, hold_cnt = 0.
- Reset mid-HOLD aborts the hold immediately and discards queued entries.
- Latency: an event first sampled at edge k is written to the FIFO at edge k. If the FSM is IDLE and the FIFO was empty, sound is registered at edge k+1 and is high for cycle k+1..k+2.
- Hold window: busy is high for exactly HOLD_CYCLES cycles following the pulse edge. The earliest next pulse is HOLD_CYCLES+1 edges after the previous pulse edge.
- Registering:
  - sound is registered (no combinational path from inputs).
  - fifo_full and busy are registered-state decodes.
- hold_cnt is 27 bits wide. HOLD_CYCLES = 1 gives one silent cycle between pulses.

## Test plan
All directed tests use HOLD_CYCLES = 8.
- Reset suppression: hold hit_p1 = 4'hF during 3 cycles of rst low, then release rst with the input still held. Required: sound stays 8'h00, drop_count = 0, busy = 0.
- Single hit: hit_p2 goes 0000→0001. Required: sound = 8'h01 for one cycle, one edge after enqueue; busy high for 8 cycles; then IDLE.
- Burst ordering: p1 lanes 3, 2, 1, 0 rise on consecutive cycles. Required: sound pulses 8'h80, 8'h40, 8'h20, 8'h10, each 9 edges apart; drop_count = 0.
- Collision: hit_p1 = 1000 and hit_p2 = 0100 rise in the same cycle. Required: only 8'h80 emitted; drop_count = 1.
- Overflow and saturation:
  - During HOLD with the FIFO empty, 6 distinct single-lane rises occur on separate cycles. Required: fifo_full asserts after the 4th; drop_count = 2; the 4 queued codes play in order.
  - 300 further forced drops. Required: drop_count saturates at 255.
- Mute: enable goes low with 3 entries queued, mid-HOLD. Required: FIFO empties, busy completes its 8 cycles, then no sound. Events while muted do not change drop_count.
